game_score_display: RTL and testbench



---
 rtl/game_score_pkg.sv | 40 ++++
 rtl/game_bin_to_bcd.sv | 52 +++++
 rtl/game_score_display.sv | 110 +++++++++++
 tb/tb_game_score_display.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_score_pkg.sv
// Shared types and constants for the score display path:
// BCD digit type, converter states, segment glyphs.
package game_score_pkg;

   localparam int MAX_BIN_BITS = 16;
   localparam int BCD_DIGITS = 5;
   localparam int SR_W = 4 * BCD_DIGITS + MAX_BIN_BITS;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } conv_state_t;

   // Segment order a..g then dp, a in the MSB.
   localparam logic [0:9][7:0] GLYPH = {
      8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
      8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6
   };

   function automatic logic [7:0] seg_of(input bcd_digit_t d);
      return (d <= 4'd9) ? GLYPH[d] : 8'h00;
   endfunction

   function automatic logic [SR_W-1:0] dd_step(
      input logic [SR_W-1:0] sr
   );
      logic [SR_W-1:0] t;
      t = sr;
      for (int k = 0; k < BCD_DIGITS; k++) begin
         if (t[MAX_BIN_BITS + 4*k +: 4] >= 4'd5)
            t[MAX_BIN_BITS + 4*k +: 4] =
               t[MAX_BIN_BITS + 4*k +: 4] + 4'd3;
      end
      return {t[SR_W-2:0], 1'b0};
   endfunction

endpackage

// File: rtl/game_bin_to_bcd.sv
// Iterative double-dabble: one add-3/shift step per cycle,
// 16 steps, then a single DONE cycle exposing the result.
module game_bin_to_bcd
   import game_score_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [MAX_BIN_BITS-1:0]   bin,
   output logic                      busy,
   output logic                      done,
   output logic [4*BCD_DIGITS-1:0]   bcd
);

   localparam int CW = $clog2(MAX_BIN_BITS);

   conv_state_t     state;
   logic [SR_W-1:0] sr;
   logic [CW-1:0]   cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sr    <= '0;
         cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  sr    <= {{(4*BCD_DIGITS){1'b0}}, bin};
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               sr  <= dd_step(sr);
               cnt <= cnt + 1'b1;
               if (cnt == CW'(MAX_BIN_BITS - 1))
                  state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // A pending request in IDLE already counts as busy.
   assign busy = (state != IDLE) | (start & ~rst);
   assign done = (state == DONE);
   assign bcd  = sr[SR_W-1 -: 4*BCD_DIGITS];

endmodule

// File: rtl/game_score_display.sv
// Score display: session high score, BCD conversion of the
// selected value, blanked and multiplexed seven-seg scan.
module game_score_display
   import game_score_pkg::*;
#(
   parameter int w_digit               = 4,
   parameter int refresh_counter_width = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [15:0]        target_count,
   input  logic               show_high,
   input  logic               clear_high,
   output logic [15:0]        high_score,
   output logic               busy,
   output logic               overflow,
   output logic [7:0]         abcdefgh,
   output logic [w_digit-1:0] digit
);

   localparam int IW = (w_digit > 1) ? $clog2(w_digit) : 1;

   logic [15:0]                      src;
   logic [15:0]                      last_converted;
   logic [15:0]                      snap;
   logic                             conv_run;
   logic                             start;
   logic                             conv_done;
   logic [4*BCD_DIGITS-1:0]          bcd;
   logic                             ovf_next;
   bcd_digit_t                       disp [w_digit];
   logic [w_digit-1:0]               blank;
   logic                             zero_run;
   logic [refresh_counter_width-1:0] refresh;
   logic [IW-1:0]                    idx;

   always_ff @(posedge clk) begin
      if (rst || clear_high)
         high_score <= '0;
      else if (target_count > high_score)
         high_score <= target_count;
   end

   assign src   = show_high ? high_score : target_count;
   assign start = ~rst & (src != last_converted);

   game_bin_to_bcd u_conv (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (src),
      .busy  (busy),
      .done  (conv_done),
      .bcd   (bcd)
   );

   always_comb begin
      ovf_next = 1'b0;
      for (int k = w_digit; k < BCD_DIGITS; k++)
         if (bcd[4*k +: 4] != 4'd0)
            ovf_next = 1'b1;
   end

   // conv_run mirrors the converter leaving IDLE, so the
   // snapshot is taken exactly when the request is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         conv_run       <= 1'b0;
         snap           <= '0;
         last_converted <= '0;
         overflow       <= 1'b0;
         for (int i = 0; i < w_digit; i++)
            disp[i] <= '0;
      end else if (conv_done) begin
         conv_run       <= 1'b0;
         last_converted <= snap;
         overflow       <= ovf_next;
         for (int i = 0; i < w_digit; i++)
            disp[i] <= ovf_next ? 4'd9 : bcd[4*i +: 4];
      end else if (start && !conv_run) begin
         conv_run <= 1'b1;
         snap     <= src;
      end
   end

   always_comb begin
      blank    = '0;
      zero_run = 1'b1;
      for (int i = w_digit - 1; i >= 0; i--) begin
         zero_run = zero_run & (disp[i] == 4'd0);
         blank[i] = (i != 0) && zero_run && !overflow;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         refresh  <= '0;
         idx      <= '0;
         digit    <= w_digit'(1);
         abcdefgh <= 8'hFC;
      end else begin
         refresh <= refresh + 1'b1;
         if (&refresh)
            idx <= (idx == IW'(w_digit - 1)) ? '0 : idx + 1'b1;
         digit    <= w_digit'(1) << idx;
         abcdefgh <= blank[idx] ? 8'h00 : seg_of(disp[idx]);
      end
   end

endmodule

// File: tb/tb_game_score_display.sv
// Randomised self-checking bench for game_score_display,
// checked against a decimal-arithmetic display model.
module tb_game_score_display;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] target_count = '0;
   logic        show_high = 1'b0;
   logic        clear_high = 1'b0;
   logic [15:0] high_score;
   logic        busy;
   logic        overflow;
   logic [7:0]  abcdefgh;
   logic [3:0]  digit;

   int n_cmp = 0;
   int n_bad = 0;
   int hm = 0;

   logic [7:0] glyph [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2,
      8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

   logic [3:0] s_dig [64];
   logic [7:0] s_seg [64];

   game_score_display #(
      .w_digit               (4),
      .refresh_counter_width (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .target_count (target_count),
      .show_high    (show_high),
      .clear_high   (clear_high),
      .high_score   (high_score),
      .busy         (busy),
      .overflow     (overflow),
      .abcdefgh     (abcdefgh),
      .digit        (digit)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_seg(int v, int i);
      int p;
      p = 1;
      for (int k = 0; k < i; k++) p = p * 10;
      if (v > 9999) return 8'hF6;
      if (i > 0 && v < p) return 8'h00;
      return glyph[(v / p) % 10];
   endfunction

   function automatic int dig_idx(logic [3:0] d);
      int r;
      int c;
      r = -1;
      c = 0;
      for (int k = 0; k < 4; k++)
         if (d[k] === 1'b1) begin
            r = k;
            c++;
         end
      return (c == 1) ? r : -1;
   endfunction

   task automatic settle(output bit ok);
      ok = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 80; k++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic scan(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         s_dig[k] = digit;
         s_seg[k] = abcdefgh;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      target_count = 16'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      hm = 0;
      @(negedge clk);
      n_cmp++;
      if (digit !== 4'b0001) begin
         n_bad++;
         $display("FAIL reset_digit: got %b want 0001", digit);
      end
      n_cmp++;
      if (abcdefgh !== 8'hFC) begin
         n_bad++;
         $display("FAIL reset_seg: got %h want fc", abcdefgh);
      end
      n_cmp++;
      if (high_score !== 16'd0) begin
         n_bad++;
         $display("FAIL reset_high: got %0d want 0", high_score);
      end
      n_cmp++;
      if (busy !== 1'b0 || overflow !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_flags: busy %b ovf %b want 0 0",
            busy, overflow);
      end
   endtask

   task automatic test_1234;
      int n;
      int run;
      int first;
      int pi;
      int ci;
      bit ok;
      target_count = 16'd1234;
      hm = 1234;
      #1;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         if (busy !== 1'b1) break;
         n++;
         @(negedge clk);
         #1;
      end
      n_cmp++;
      if (n != 18) begin
         n_bad++;
         $display("FAIL busy_len: got %0d want 18", n);
      end
      settle(ok);
      scan(32);
      for (int k = 0; k < 32; k++) begin
         ci = dig_idx(s_dig[k]);
         n_cmp++;
         if (ci < 0 || s_seg[k] !== exp_seg(1234, ci)) begin
            n_bad++;
            $display("FAIL scan_1234: dig %b seg %h want %h",
               s_dig[k], s_seg[k], exp_seg(1234, ci < 0 ? 0 : ci));
         end
      end
      run = 1;
      first = 1;
      pi = dig_idx(s_dig[0]);
      for (int k = 1; k < 32; k++) begin
         ci = dig_idx(s_dig[k]);
         if (ci == pi) begin
            run++;
         end else begin
            n_cmp++;
            if ((!first && run != 4) || ci != (pi + 1) % 4) begin
               n_bad++;
               $display("FAIL scan_step: run %0d idx %0d->%0d want 4",
                  run, pi, ci);
            end
            first = 0;
            run = 1;
            pi = ci;
         end
      end
      n_cmp++;
      if (high_score !== 16'd1234) begin
         n_bad++;
         $display("FAIL high_1234: got %0d want 1234", high_score);
      end
   endtask

   task automatic test_blanking;
      int vals [2] = '{7, 10};
      int ci;
      bit ok;
      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         target_count = 16'(vals[j]);
         settle(ok);
         n_cmp++;
         if (!ok) begin
            n_bad++;
            $display("FAIL blank_timeout: busy 1 want 0");
         end
         scan(16);
         for (int k = 0; k < 16; k++) begin
            ci = dig_idx(s_dig[k]);
            n_cmp++;
            if (ci < 0 || s_seg[k] !== exp_seg(vals[j], ci)) begin
               n_bad++;
               $display("FAIL blank_%0d: dig %b seg %h want %h",
                  vals[j], s_dig[k], s_seg[k],
                  exp_seg(vals[j], ci < 0 ? 0 : ci));
            end
         end
      end
   endtask

   task automatic test_high_score;
      int n;
      int ci;
      bit ok;
      @(negedge clk);
      rst = 1'b1;
      target_count = 16'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      hm = 0;
      for (int v = 1; v <= 5; v++) begin
         target_count = 16'(v);
         if (v > hm) hm = v;
         @(negedge clk);
      end
      target_count = 16'd0;
      @(negedge clk);
      n_cmp++;
      if (high_score !== 16'(hm)) begin
         n_bad++;
         $display("FAIL high_max: got %0d want %0d", high_score, hm);
      end
      settle(ok);
      show_high = 1'b1;
      #1;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         if (busy !== 1'b1) break;
         n++;
         @(negedge clk);
         #1;
      end
      n_cmp++;
      if (n == 0 || n > 18) begin
         n_bad++;
         $display("FAIL high_latency: got %0d want 1..18", n);
      end
      repeat (2) @(negedge clk);
      scan(16);
      for (int k = 0; k < 16; k++) begin
         ci = dig_idx(s_dig[k]);
         n_cmp++;
         if (ci < 0 || s_seg[k] !== exp_seg(hm, ci)) begin
            n_bad++;
            $display("FAIL show_high: dig %b seg %h want %h",
               s_dig[k], s_seg[k], exp_seg(hm, ci < 0 ? 0 : ci));
         end
      end
      clear_high = 1'b1;
      target_count = 16'd3;
      @(negedge clk);
      clear_high = 1'b0;
      n_cmp++;
      if (high_score !== 16'd0) begin
         n_bad++;
         $display("FAIL clear_wins: got %0d want 0", high_score);
      end
      @(negedge clk);
      hm = 3;
      n_cmp++;
      if (high_score !== 16'd3) begin
         n_bad++;
         $display("FAIL after_clear: got %0d want 3", high_score);
      end
      show_high = 1'b0;
      settle(ok);
   endtask

   task automatic test_overflow;
      int vals [2] = '{12345, 42};
      int ci;
      bit ok;
      for (int j = 0; j < 2; j++) begin
         target_count = 16'(vals[j]);
         if (vals[j] > hm) hm = vals[j];
         settle(ok);
         n_cmp++;
         if (overflow !== (vals[j] > 9999)) begin
            n_bad++;
            $display("FAIL ovf_%0d: got %b want %b",
               vals[j], overflow, vals[j] > 9999);
         end
         scan(16);
         for (int k = 0; k < 16; k++) begin
            ci = dig_idx(s_dig[k]);
            n_cmp++;
            if (ci < 0 || s_seg[k] !== exp_seg(vals[j], ci)) begin
               n_bad++;
               $display("FAIL ovf_scan_%0d: dig %b seg %h want %h",
                  vals[j], s_dig[k], s_seg[k],
                  exp_seg(vals[j], ci < 0 ? 0 : ci));
            end
         end
      end
   endtask

   task automatic test_midshift;
      int ci;
      int tot;
      bit ok;
      target_count = 16'd100;
      settle(ok);
      target_count = 16'd42;
      repeat (9) @(negedge clk);
      target_count = 16'd43;
      repeat (11) @(negedge clk);
      scan(12);
      for (int k = 0; k < 12; k++) begin
         ci = dig_idx(s_dig[k]);
         n_cmp++;
         if (ci < 0 || s_seg[k] !== exp_seg(42, ci)) begin
            n_bad++;
            $display("FAIL mid_old: dig %b seg %h want %h",
               s_dig[k], s_seg[k], exp_seg(42, ci < 0 ? 0 : ci));
         end
      end
      tot = 23;
      for (int k = 0; k < 40; k++) begin
         if (!busy) break;
         @(negedge clk);
         tot++;
      end
      n_cmp++;
      if (tot > 36) begin
         n_bad++;
         $display("FAIL mid_latency: got %0d want <=36", tot);
      end
      repeat (2) @(negedge clk);
      scan(16);
      for (int k = 0; k < 16; k++) begin
         ci = dig_idx(s_dig[k]);
         n_cmp++;
         if (ci < 0 || s_seg[k] !== exp_seg(43, ci)) begin
            n_bad++;
            $display("FAIL mid_new: dig %b seg %h want %h",
               s_dig[k], s_seg[k], exp_seg(43, ci < 0 ? 0 : ci));
         end
      end
      target_count = 16'd9000;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || digit !== 4'b0001) begin
         n_bad++;
         $display("FAIL mid_rst: busy %b dig %b want 0 0001",
            busy, digit);
      end
      n_cmp++;
      if (abcdefgh !== 8'hFC || high_score !== 16'd0) begin
         n_bad++;
         $display("FAIL mid_rst_seg: seg %h high %0d want fc 0",
            abcdefgh, high_score);
      end
      target_count = 16'd0;
      hm = 0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_random;
      int v;
      int sh;
      int src;
      int ci;
      bit ok;
      for (int it = 0; it < 24; it++) begin
         v = (it % 6 == 5) ? int'($urandom_range(10000, 65535))
                           : int'($urandom_range(0, 9999));
         sh = int'($urandom_range(0, 1));
         target_count = 16'(v);
         show_high = sh[0];
         if (v > hm) hm = v;
         src = sh ? hm : v;
         settle(ok);
         n_cmp++;
         if (!ok || high_score !== 16'(hm)) begin
            n_bad++;
            $display("FAIL rnd_high: got %0d want %0d ok %b",
               high_score, hm, ok);
         end
         n_cmp++;
         if (overflow !== (src > 9999)) begin
            n_bad++;
            $display("FAIL rnd_ovf: src %0d got %b", src, overflow);
         end
         scan(16);
         for (int k = 0; k < 16; k++) begin
            ci = dig_idx(s_dig[k]);
            n_cmp++;
            if (ci < 0 || s_seg[k] !== exp_seg(src, ci)) begin
               n_bad++;
               $display("FAIL rnd_scan %0d: dig %b seg %h want %h",
                  src, s_dig[k], s_seg[k],
                  exp_seg(src, ci < 0 ? 0 : ci));
            end
         end
      end
      show_high = 1'b0;
   endtask

   initial begin
      test_reset();
      test_1234();
      test_blanking();
      test_high_score();
      test_overflow();
      test_midshift();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
         n_cmp, n_bad);
      $finish;
   end

endmodule
